// File: rtl/y86_regfile_wb_if.sv
// Decode/write-back bus between the pipeline control side and the register file.
interface y86_regfile_wb_if;
  // Instruction fields and write-back payload toward the register file
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        Cnd;
  logic        wb_en;
  logic [63:0] valE;
  logic [63:0] valM;
  // Decoded register IDs and operand values back toward execute
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valA;
  logic [63:0] valB;

  modport master (
    output icode, rA, rB, Cnd, wb_en, valE, valM,
    input  srcA, srcB, dstE, dstM, valA, valB
  );

  modport slave (
    input  icode, rA, rB, Cnd, wb_en, valE, valM,
    output srcA, srcB, dstE, dstM, valA, valB
  );
endinterface

// File: rtl/y86_regfile_wb.sv
// Y86-64 decode and write-back: register ID decode, combinational operand
// read and clocked commit of valE/valM into a 15-entry register file.
module y86_regfile_wb #(
  parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200,
  parameter logic [63:0] REG_INIT   = 64'h0
) (
  input logic             clk,
  input logic             reset,
  y86_regfile_wb_if.slave bus
);

  localparam int unsigned NumRegs = 15;

  localparam logic [3:0] RegNone = 4'hF;
  localparam logic [3:0] RegRsp  = 4'h4;

  localparam logic [3:0] IRrmovq = 4'h2;
  localparam logic [3:0] IIrmovq = 4'h3;
  localparam logic [3:0] IRmmovq = 4'h4;
  localparam logic [3:0] IMrmovq = 4'h5;
  localparam logic [3:0] IOpq    = 4'h6;
  localparam logic [3:0] ICall   = 4'h8;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPushq  = 4'hA;
  localparam logic [3:0] IPopq   = 4'hB;

  logic [63:0] regs_q [NumRegs];
  logic [63:0] regs_d [NumRegs];

  logic [3:0] src_a;
  logic [3:0] src_b;
  logic [3:0] dst_e;
  logic [3:0] dst_m;

  // Register ID decode; unlisted icodes (including C..F) select no register
  always_comb begin
    src_a = RegNone;
    src_b = RegNone;
    dst_e = RegNone;
    dst_m = RegNone;
    case (bus.icode)
      IRrmovq: begin
        src_a = bus.rA;
        dst_e = bus.Cnd ? bus.rB : RegNone;  // cmovXX commits only when taken
      end
      IIrmovq: begin
        dst_e = bus.rB;
      end
      IRmmovq: begin
        src_a = bus.rA;
        src_b = bus.rB;
      end
      IMrmovq: begin
        src_b = bus.rB;
        dst_m = bus.rA;
      end
      IOpq: begin
        src_a = bus.rA;
        src_b = bus.rB;
        dst_e = bus.rB;
      end
      ICall: begin
        src_b = RegRsp;
        dst_e = RegRsp;
      end
      IRet: begin
        src_a = RegRsp;
        src_b = RegRsp;
        dst_e = RegRsp;
      end
      IPushq: begin
        src_a = bus.rA;
        src_b = RegRsp;
        dst_e = RegRsp;
      end
      IPopq: begin
        src_a = RegRsp;
        src_b = RegRsp;
        dst_e = RegRsp;
        dst_m = bus.rA;
      end
      default: ;
    endcase
  end

  // Drive decoded IDs and read operands; ID F reads as zero, no bypass
  always_comb begin
    bus.srcA = src_a;
    bus.srcB = src_b;
    bus.dstE = dst_e;
    bus.dstM = dst_m;
    bus.valA = (src_a == RegNone) ? 64'h0 : regs_q[src_a];
    bus.valB = (src_b == RegNone) ? 64'h0 : regs_q[src_b];
  end

  // Next register contents; the valM port takes priority when both target one ID
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = regs_q[i];
      if (bus.wb_en) begin
        if (dst_m == 4'(i)) begin
          regs_d[i] = bus.valM;
        end else if (dst_e == 4'(i)) begin
          regs_d[i] = bus.valE;
        end
      end
    end
  end

  // Register file state; reset discards any pending write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= (4'(i) == RegRsp) ? STACK_INIT : REG_INIT;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: doc/y86_regfile_wb.md
# y86_regfile_wb

- Sequential-design decode/write-back block for the Y86-64 core.
- Decode side: derives source and destination register IDs from `icode`, `rA`, `rB` and the execute-stage `Cnd` flag, and drives `valA`/`valB` toward the ALU operand selectors.
- Write-back side: consumes the execute result `valE` and the memory result `valM`, and commits them to a 15-entry 64-bit register file on the clock edge.
- It is the consumer/producer counterpart of the execute stage: it feeds the operands and receives the result.

## Interface
Parameters:
- `STACK_INIT`, 64'h0000_0000_0000_0200: reset value of `%rsp` (ID 4).
- `REG_INIT`, 64'h0: reset value of every other register.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `icode` in 4: instruction code of the current instruction.
- `rA` in 4: register specifier A.
- `rB` in 4: register specifier B.
- `Cnd` in 1: condition result from execute; gates `cmovXX` writes.
- `wb_en` in 1: commit strobe; write-back occurs only when high.
- `valE` in 64: execute result.
- `valM` in 64: memory read result.
- `srcA` out 4: decoded source A (4'hF = none).
- `srcB` out 4: decoded source B (4'hF = none).
- `dstE` out 4: decoded valE destination.
- `dstM` out 4: decoded valM destination.
- `valA` out 64: contents of register `srcA`; 0 when `srcA`=F.
- `valB` out 64: contents of register `srcB`; 0 when `srcB`=F.

## Operation
- Storage: registers 0..14, 64 bits each. ID F is "no register": it is never written and always reads 0.

Decode (combinational):
- `srcA` = `rA` for icode {2,4,6,A}; 4 for {9,B}; else F.
- `srcB` = `rB` for {4,5,6}; 4 for {8,9,A,B}; else F.
- `dstE`:
  - icode 2: `rB` if `Cnd`=1, else F.
  - icode {3,6}: `rB`.
  - icode {8,9,A,B}: 4.
  - else: F.
- `dstM` = `rA` for {5,B}; else F.
- Undefined icodes (C..F) decode all four IDs to F.

Read:
- `valA`/`valB` are combinational from the current register contents.
- There is no write-to-read bypass: a value written on edge N is visible on the read ports after edge N.

Write-back (at rising `clk`, when `wb_en`=1 and `reset`=0):
- if `dstE`≠F: reg[`dstE`] ← `valE`.
- if `dstM`≠F: reg[`dstM`] ← `valM`.
- If `dstE`=`dstM`≠F (popq %rsp), `valM` wins.

## Timing
- Reset: on any rising edge with `reset`=1:
  - reg[4] ← `STACK_INIT`; all other registers ← `REG_INIT`.
  - `reset` overrides `wb_en`, including a write pending in the same cycle.
  - From the following cycle `valA`/`valB` reflect the reset contents.
  - Decode outputs are combinational and are unaffected by reset.
- Write latency: 1 edge. Read latency: 0 (combinational).
- Reset mid-operation: an instruction in flight is discarded with no partial write. Decoding resumes normally once `reset` deasserts.
- `wb_en`=0: no register changes, regardless of `dstE`/`dstM`.
- `Cnd` is sampled combinationally through `dstE` at the write edge; it must be stable before that edge.

## Test plan
- Reset with `STACK_INIT`=0x200 -> icode 6 with rA=4, rB=0 reads `valA`=0x200, `valB`=0. rA=F reads `valA`=0.
- irmovq: icode 3, rB=2, `valE`=0x1234, `wb_en`=1, one edge -> next cycle icode 2 with rA=2 reads `valA`=0x1234. Same stimulus with `wb_en`=0 leaves reg2=0.
- cmovXX: icode 2, rA=2, rB=3, `valE`=0x1234:
  - `Cnd`=0 -> `dstE`=F, reg3 unchanged.
  - `Cnd`=1 -> reg3=0x1234.
- pushq/popq:
  - icode A, rA=1, `valE`=0x1F8 -> `srcA`=1, `srcB`=4, `dstE`=4, `%rsp`=0x1F8.
  - icode B, rA=4, `valE`=0x200, `valM`=0x55 -> `%rsp`=0x55 (`valM` wins).
- mrmovq: icode 5, rA=7, rB=2 -> `dstM`=7, `dstE`=F. `valM`=0xDEAD commits to reg7 only.
- Reset mid-write: `reset`=1 and `wb_en`=1 with `dstE`=3, `valE`=0x99 on the same edge -> reg3=0, `%rsp`=0x200.
